// File: rtl/ex_muldiv_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 op codes,
// FSM state encoding and small op-decode helpers.
package ex_muldiv_seq_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mds_state_e;

  // Operand A is treated as two's complement for these ops.
  function automatic logic op_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Operand B is treated as two's complement for these ops.
  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // Signed divide ops (DIV, REM) are the only ones that can overflow.
  function automatic logic op_is_sdiv(input logic [2:0] op);
    return op[2] & ~op[0];
  endfunction

endpackage

// File: rtl/ex_muldiv_seq_muldiv_core.sv
// Radix-2 datapath for the multiply/divide sequencer. Holds the double-width
// accumulator and the second operand; performs one shift-add (multiply) or one
// restoring-divide step per step_i. The post-step value is exposed
// combinationally so the controller can capture the final result on the same
// edge as the last step.
module ex_muldiv_seq_muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              finish_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_nxt_o
);

  // Multiply: acc = {partial_hi, multiplier_remaining}; opnd = multiplicand.
  // Divide:   acc = {remainder, dividend_remaining/quotient}; opnd = divisor.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              is_div_q, is_div_d;

  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     rem_shift;
  logic [XLEN-1:0]   trial;
  logic [2*XLEN-1:0] mul_nxt;
  logic [2*XLEN-1:0] div_nxt;

  // One iteration of either algorithm, computed from the current registers.
  always_comb begin
    add_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nxt   = {add_sum, acc_q[XLEN-1:1]};
    rem_shift = acc_q[2*XLEN-1:XLEN-1];
    // The remainder is always below the divisor, so a successful subtract
    // fits in XLEN bits and the borrow bit is never needed.
    trial     = rem_shift[XLEN-1:0] - opnd_q;
    if (rem_shift >= {1'b0, opnd_q}) begin
      div_nxt = {trial, acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_nxt = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
    acc_nxt_o = is_div_q ? div_nxt : mul_nxt;
  end

  // Load, step or clear the working registers under controller strobes.
  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    if (load_i) begin
      is_div_d = is_div_i;
      if (is_div_i) begin
        acc_d  = {{XLEN{1'b0}}, a_i};
        opnd_d = b_i;
      end else begin
        acc_d  = {{XLEN{1'b0}}, b_i};
        opnd_d = a_i;
      end
    end else if (finish_i) begin
      acc_d    = '0;
      opnd_d   = '0;
      is_div_d = 1'b0;
    end else if (step_i) begin
      acc_d = acc_nxt_o;
    end
  end

  // Working register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// RV32M multiply/divide sequencer beside the EX stage. Stalls the pipeline
// while the iterative core runs, resolves operand signs and divide corner
// cases locally, and presents the result with a one-cycle done pulse.
//
//  state | meaning
//  IDLE  | waiting for an M-op; stall_o follows an accepted start combinationally
//  BUSY  | core iterating, one step per cycle for XLEN cycles
//  DONE  | result_o/rd_o valid, done_o pulses, pipeline released
module ex_muldiv_seq
  import ex_muldiv_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  mds_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [4:0]        rd_pend_q, rd_pend_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;
  // Previous completed result, restored if the op is flushed in its DONE cycle.
  logic [XLEN-1:0]   result_prev_q, result_prev_d;
  logic [4:0]        rd_prev_q, rd_prev_d;

  logic              sgn_a, sgn_b;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              is_div;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;

  logic              core_load, core_step, core_finish;
  logic [2*XLEN-1:0] acc_nxt;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   fin_res;

  ex_muldiv_seq_muldiv_core #(.XLEN(XLEN)) u_muldiv_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (core_load),
    .step_i    (core_step),
    .finish_i  (core_finish),
    .is_div_i  (is_div),
    .a_i       (a_mag),
    .b_i       (b_mag),
    .acc_nxt_o (acc_nxt)
  );

  // Operand magnitudes and divide special-case detection on the incoming op.
  always_comb begin
    sgn_a    = op_signed_a(op_i) & rs1_i[XLEN-1];
    sgn_b    = op_signed_b(op_i) & rs2_i[XLEN-1];
    a_mag    = sgn_a ? -rs1_i : rs1_i;
    b_mag    = sgn_b ? -rs2_i : rs2_i;
    is_div   = op_is_div(op_i);
    div_zero = (rs2_i == '0);
    div_ovf  = op_is_sdiv(op_i) && (rs1_i == XMIN) && (rs2_i == '1);
    special  = is_div && (div_zero || div_ovf);
    special_res = '0;
    if (div_zero) begin
      special_res = op_is_rem(op_i) ? rs1_i : '1;
    end else if (div_ovf) begin
      special_res = op_is_rem(op_i) ? '0 : XMIN;
    end
  end

  // Sign fix-up and result select from the core's final-step value.
  always_comb begin
    prod_fix = neg_quo_q ? -acc_nxt : acc_nxt;
    quo_fix  = neg_quo_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem_fix  = neg_rem_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    if (op_is_div(op_q)) begin
      fin_res = op_is_rem(op_q) ? rem_fix : quo_fix;
    end else if (op_q == OP_MUL) begin
      fin_res = prod_fix[XLEN-1:0];
    end else begin
      fin_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  // Sequencer next-state, strobes and combinational outputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    rd_pend_d     = rd_pend_q;
    result_d      = result_q;
    rd_out_d      = rd_out_q;
    result_prev_d = result_prev_q;
    rd_prev_d     = rd_prev_q;
    core_load     = 1'b0;
    core_step     = 1'b0;
    core_finish   = 1'b0;
    stall_o       = 1'b0;
    done_o        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          stall_o   = 1'b1;
          op_d      = op_i;
          neg_quo_d = sgn_a ^ sgn_b;
          neg_rem_d = sgn_a;
          rd_pend_d = rd_i;
          cnt_d     = '0;
          if (special) begin
            state_d       = ST_DONE;
            result_prev_d = result_q;
            rd_prev_d     = rd_out_q;
            result_d      = special_res;
            rd_out_d      = rd_i;
          end else begin
            state_d   = ST_BUSY;
            core_load = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          core_finish = 1'b1;
        end else begin
          core_step = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d       = ST_DONE;
            core_finish   = 1'b1;
            result_prev_d = result_q;
            rd_prev_d     = rd_out_q;
            result_d      = fin_res;
            rd_out_d      = rd_pend_q;
          end
        end
      end
      ST_DONE: begin
        done_o  = !flush_i;
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (flush_i) begin
          result_d = result_prev_q;
          rd_out_d = rd_prev_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      rd_pend_q     <= '0;
      result_q      <= '0;
      rd_out_q      <= '0;
      result_prev_q <= '0;
      rd_prev_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      rd_pend_q     <= rd_pend_d;
      result_q      <= result_d;
      rd_out_q      <= rd_out_d;
      result_prev_q <= result_prev_d;
      rd_prev_q     <= rd_prev_d;
    end
  end

  assign busy_o   = (state_q != ST_IDLE);
  assign result_o = result_q;
  assign rd_o     = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Bench for the multiply/divide sequencer: an arithmetic reference model with
// timestamp-based expectations checked every cycle, plus directed vectors with
// hand-computed results and latencies.
module tb_ex_muldiv_seq;
  import ex_muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int total = 0;
  int bad   = 0;

  ex_muldiv_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .rd_i     (rd_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .rd_o     (rd_o)
  );

  always #5 clk = ~clk;

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (op)
      OP_MUL:    begin p = ua * ub; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; p = q; return p[31:0];
      end
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; p = q; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < OP_DIV) return 1'b0;
    if (b == 0) return 1'b1;
    return (op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Model: an accepted op at cycle T finishes at T+latency; busy in between.
  int          cyc = 0;
  int          cp;
  bit          active = 0;
  int          t_start = 0, t_done = 0;
  logic [31:0] m_res = '0, pend_res = '0, old_res = '0;
  logic [4:0]  m_rd = '0, pend_rd = '0, old_rd = '0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    cp  = cyc;
    cyc = cyc + 1;
    if (!rst_n) begin
      active = 0;
      m_res  = '0;
      m_rd   = '0;
    end else if (active) begin
      if (flush_i) begin
        if (cp == t_done) begin
          m_res = old_res;
          m_rd  = old_rd;
        end
        active = 0;
      end else if (cp == t_done) begin
        active = 0;
      end
    end else if (start_i && !flush_i) begin
      active   = 1;
      t_start  = cp;
      t_done   = cp + (is_special(op_i, rs1_i, rs2_i) ? 1 : 33);
      pend_res = ref_op(op_i, rs1_i, rs2_i);
      pend_rd  = rd_i;
    end
    if (active && cyc == t_done) begin
      old_res = m_res;
      old_rd  = m_rd;
      m_res   = pend_res;
      m_rd    = pend_rd;
    end
  end

  logic e_busy, e_done, e_stall;
  always @(negedge clk) begin
    if (chk_en) begin
      e_busy  = active;
      e_done  = active && (cyc == t_done) && !flush_i;
      e_stall = (active && cyc < t_done) || (!active && start_i && !flush_i);
      total++;
      if (busy_o !== e_busy || done_o !== e_done || stall_o !== e_stall ||
          result_o !== m_res || rd_o !== m_rd) begin
        bad++;
        $display("FAIL cycle_check cyc=%0d got busy=%b done=%b stall=%b res=%h rd=%0d exp busy=%b done=%b stall=%b res=%h rd=%0d",
                 cyc, busy_o, done_o, stall_o, result_o, rd_o, e_busy, e_done, e_stall, m_res, m_rd);
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic wait_done(input string nm, input int ts, input int lat,
                           input logic [31:0] er, input logic [4:0] erd);
    int n;
    bit got;
    n   = 0;
    got = 0;
    while (!got && n < 80) begin
      @(negedge clk);
      if (done_o === 1'b1) got = 1;
      n++;
    end
    check({nm, "_done_seen"}, 64'(got), 64'd1);
    if (got) begin
      check({nm, "_latency"}, 64'(cyc - ts), 64'(lat));
      check({nm, "_result"}, 64'(result_o), 64'(er));
      check({nm, "_rd"}, 64'(rd_o), 64'(erd));
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] er, input int lat);
    int ts;
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
    ts = cyc;
    @(posedge clk); #1;
    start_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom; op_i = 3'($urandom_range(0, 7));
    wait_done(nm, ts, lat, er, rd);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  int ts;
  initial begin
    rst_n = 1'b0; start_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    check("rst_result", 64'(result_o), 64'd0);
    check("rst_rd", 64'(rd_o), 64'd0);

    run_op("mulhu_max",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 33);
    run_op("mul_neg",     OP_MUL,    32'hFFFF_FFFD, 32'd7,         5'd2,  32'hFFFF_FFEB, 33);
    run_op("mulh_min",    OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd3,  32'h4000_0000, 33);
    run_op("mulhsu_min",  OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 33);
    run_op("mulhsu_neg1", OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd14, 32'hFFFF_FFFF, 33);
    run_op("mul_zero",    OP_MUL,    32'd5,         32'd0,         5'd15, 32'd0,         33);
    run_op("div_neg",     OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD, 33);
    run_op("rem_neg",     OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFF, 33);
    run_op("divu",        OP_DIVU,   32'd100,       32'd7,         5'd6,  32'd14,        33);
    run_op("div_by0",     OP_DIV,    32'd1234,      32'd0,         5'd8,  32'hFFFF_FFFF, 1);
    run_op("rem_by0",     OP_REM,    32'd5,         32'd0,         5'd9,  32'd5,         1);
    run_op("divu_by0",    OP_DIVU,   32'd7,         32'd0,         5'd16, 32'hFFFF_FFFF, 1);
    run_op("remu_by0",    OP_REMU,   32'h0000_DEAD, 32'd0,         5'd17, 32'h0000_DEAD, 1);
    run_op("div_ovf",     OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
    run_op("rem_ovf",     OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         1);
    run_op("remu",        OP_REMU,   32'd100,       32'd7,         5'd7,  32'd2,         33);

    // Flush a DIVU at T+10, then start a new op right away at T+11.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = OP_DIVU; rs1_i = 32'd1000; rs2_i = 32'd7; rd_i = 5'd20;
    ts = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    start_i = 1'b1; op_i = OP_DIVU; rs1_i = 32'd1000; rs2_i = 32'd3; rd_i = 5'd10;
    check("flush_idle_cycle", 64'(cyc - ts), 64'd11);
    ts = cyc;
    @(negedge clk);
    check("flush_busy", 64'(busy_o), 64'd0);
    check("flush_result_kept", 64'(result_o), 64'd2);
    check("flush_rd_kept", 64'(rd_o), 64'd7);
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done("b2b_divu", ts, 33, 32'd333, 5'd10);

    // Reset in the middle of a MUL, then a start that arrives with a flush.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = OP_MUL; rs1_i = 32'd9; rs2_i = 32'd9; rd_i = 5'd21;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_done", 64'(done_o), 64'd0);
    check("midrst_stall", 64'(stall_o), 64'd0);
    check("midrst_result", 64'(result_o), 64'd0);
    check("midrst_rd", 64'(rd_o), 64'd0);
    @(posedge clk); #1;
    start_i = 1'b1; flush_i = 1'b1; op_i = OP_MUL; rs1_i = 32'd3; rs2_i = 32'd3; rd_i = 5'd22;
    @(negedge clk);
    check("startflush_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    check("startflush_busy", 64'(busy_o), 64'd0);

    run_op("post_rst_mul", OP_MUL, 32'd12345, 32'd678, 5'd23, 32'd8369910, 33);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
